microcode_sequencer: RTL and testbench

- Micro-program counter (uPC) controller for the microcoded accumulator CPU.
- Each cycle it selects the next microcode ROM address from the current microword's sequencing field.
- Sources are the uPC increment, an absolute target, or the dispatch offset from the opcode decoder.
- It also detects the decoder's illegal-opcode sentinel, implements halt/resume, and counts dispatched instructions.

---
 rtl/microcode_sequencer.sv | 147 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// ---------------------------------------------------------------------------
// microcode_sequencer
//
// Micro-program counter controller for the microcoded accumulator CPU.
// Each cycle it picks the next microcode ROM address from the sequencing
// field of the current microword: increment, absolute jump, or dispatch
// through the opcode decoder. It also traps the decoder's illegal-opcode
// sentinel (all-ones offset), implements halt/resume and counts the number
// of successful dispatches (saturating).
//
// Ports:
//   clk          in   rising-edge system clock
//   rst          in   synchronous active-high reset
//   stall        in   memory/bus wait, freezes all state while running
//   op_offset    in   [MC_WIDTH]  dispatch offset, all-ones = illegal opcode
//   mc_seq       in   [2]  00 NEXT, 01 DISPATCH, 10 JUMP, 11 HALT
//   mc_target    in   [MC_WIDTH]  absolute jump target
//   resume       in   restart after a non-illegal HALT
//   upc          out  [MC_WIDTH]  registered microcode ROM address
//   halted       out  sequencer is in HALT (registered)
//   illegal      out  sticky, halt caused by illegal opcode (registered)
//   instr_count  out  [CNT_WIDTH] saturating dispatch counter
// ---------------------------------------------------------------------------
`ifndef MC_OFFSET_WIDTH
`define MC_OFFSET_WIDTH 6
`endif

module microcode_sequencer #(
    parameter int MC_WIDTH   = `MC_OFFSET_WIDTH,
    parameter int FETCH_ADDR = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [MC_WIDTH-1:0]  op_offset,
    input  logic [1:0]           mc_seq,
    input  logic [MC_WIDTH-1:0]  mc_target,
    input  logic                 resume,
    output logic [MC_WIDTH-1:0]  upc,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [1:0] SEQ_NEXT     = 2'b00;
    localparam logic [1:0] SEQ_DISPATCH = 2'b01;
    localparam logic [1:0] SEQ_JUMP     = 2'b10;
    localparam logic [1:0] SEQ_HALT     = 2'b11;

    localparam logic [MC_WIDTH-1:0]  FETCH_UPC   = MC_WIDTH'(FETCH_ADDR);
    localparam logic [MC_WIDTH-1:0]  UPC_ONE     = {{(MC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MC_WIDTH-1:0]  ILLEGAL_OFS = {MC_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

    logic [0:0]           state_q,   state_d;
    logic [MC_WIDTH-1:0]  upc_q,     upc_d;
    logic                 illegal_q, illegal_d;
    logic                 halted_q,  halted_d;
    logic [CNT_WIDTH-1:0] count_q,   count_d;

    // Next-state / next-address selection for the RUN and HALT states.
    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    case (mc_seq)
                        SEQ_NEXT: begin
                            // Natural wrap of the MC_WIDTH adder gives modulo behaviour.
                            upc_d = upc_q + UPC_ONE;
                        end
                        SEQ_DISPATCH: begin
                            if (op_offset == ILLEGAL_OFS) begin
                                state_d   = ST_HALT;
                                illegal_d = 1'b1;
                            end else begin
                                upc_d = op_offset;
                                if (count_q != CNT_MAX) begin
                                    count_d = count_q + CNT_ONE;
                                end else begin
                                    count_d = count_q;
                                end
                            end
                        end
                        SEQ_JUMP: begin
                            upc_d = mc_target;
                        end
                        SEQ_HALT: begin
                            state_d = ST_HALT;
                        end
                        default: begin
                            upc_d = upc_q;
                        end
                    endcase
                end else begin
                    // Stall freezes everything, including a pending illegal trap.
                    state_d = state_q;
                end
            end
            ST_HALT: begin
                // An illegal halt can only be left through rst.
                if (resume && !illegal_q) begin
                    state_d = ST_RUN;
                    upc_d   = FETCH_UPC;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_RUN;
                upc_d   = FETCH_UPC;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            upc_q     <= FETCH_UPC;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
        end
    end

    assign upc         = upc_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [5:0]  op_offset;
    logic [1:0]  mc_seq;
    logic [5:0]  mc_target;
    logic        resume;
    logic [5:0]  upc;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;
    logic [5:0]  upc_s;
    logic        halted_s;
    logic        illegal_s;
    logic [3:0]  instr_count_s;

    int checks;
    int errors;

    microcode_sequencer #(.MC_WIDTH(6), .FETCH_ADDR(0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .op_offset(op_offset),
        .mc_seq(mc_seq), .mc_target(mc_target), .resume(resume),
        .upc(upc), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    // Narrow counter copy so saturation is reachable in a few cycles.
    microcode_sequencer #(.MC_WIDTH(6), .FETCH_ADDR(0), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .op_offset(op_offset),
        .mc_seq(mc_seq), .mc_target(mc_target), .resume(resume),
        .upc(upc_s), .halted(halted_s), .illegal(illegal_s), .instr_count(instr_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [5:0] e_upc, input logic e_halt,
                             input logic e_ill, input logic [15:0] e_cnt);
        check({tag, ".upc"},     32'(upc),         32'(e_upc));
        check({tag, ".halted"},  32'(halted),      32'(e_halt));
        check({tag, ".illegal"}, 32'(illegal),     32'(e_ill));
        check({tag, ".count"},   32'(instr_count), 32'(e_cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; stall = 1'b0; op_offset = 6'h00; mc_seq = 2'b00;
        mc_target = 6'h00; resume = 1'b0;
        step(); step();
        check_all("reset", 6'h00, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        // NEXT increments
        mc_seq = 2'b00;
        step(); check_all("next1", 6'h01, 1'b0, 1'b0, 16'h0000);
        step(); check_all("next2", 6'h02, 1'b0, 1'b0, 16'h0000);
        step(); check_all("next3", 6'h03, 1'b0, 1'b0, 16'h0000);
        step(); step(); check("next5.upc", 32'(upc), 32'h05);

        // Dispatch then jump
        mc_seq = 2'b01; op_offset = 6'h0a;
        step(); check_all("disp0a", 6'h0a, 1'b0, 1'b0, 16'h0001);
        mc_seq = 2'b10; mc_target = 6'h0e;
        step(); check_all("jump0e", 6'h0e, 1'b0, 1'b0, 16'h0001);

        // Stalled dispatch
        stall = 1'b1; mc_seq = 2'b01; op_offset = 6'h16;
        for (int i = 0; i < 4; i++) begin
            step(); check_all("stall", 6'h0e, 1'b0, 1'b0, 16'h0001);
        end
        stall = 1'b0;
        step(); check_all("disp16", 6'h16, 1'b0, 1'b0, 16'h0002);

        // Illegal dispatch, resume ignored
        op_offset = 6'h3f;
        step(); check_all("illegal", 6'h16, 1'b1, 1'b1, 16'h0002);
        resume = 1'b1; mc_seq = 2'b00;
        step(); step(); check_all("ill_resume", 6'h16, 1'b1, 1'b1, 16'h0002);
        resume = 1'b0;
        stall = 1'b1;
        rst = 1'b1;
        step(); check_all("rst_ill", 6'h00, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0; stall = 1'b0;

        // HALT microop, frozen, then resume
        mc_seq = 2'b00;
        step(); check("pre_halt.upc", 32'(upc), 32'h01);
        mc_seq = 2'b11;
        step(); check_all("halt", 6'h01, 1'b1, 1'b0, 16'h0000);
        mc_seq = 2'b00;
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            step(); check_all("halt_hold", 6'h01, 1'b1, 1'b0, 16'h0000);
        end
        stall = 1'b0;
        resume = 1'b1;
        step(); check_all("resume", 6'h00, 1'b0, 1'b0, 16'h0000);
        // resume while running is ignored
        step(); check_all("resume_run", 6'h01, 1'b0, 1'b0, 16'h0000);
        resume = 1'b0;

        // Wrap from all-ones
        mc_seq = 2'b10; mc_target = 6'h3f;
        step(); check("jump3f.upc", 32'(upc), 32'h3f);
        mc_seq = 2'b00;
        step(); check("wrap.upc", 32'(upc), 32'h00);

        // Stalled illegal dispatch: no halt until stall drops
        stall = 1'b1; mc_seq = 2'b01; op_offset = 6'h3f;
        step(); check_all("stall_ill", 6'h00, 1'b0, 1'b0, 16'h0000);
        stall = 1'b0;
        step(); check_all("ill_late", 6'h00, 1'b1, 1'b1, 16'h0000);
        rst = 1'b1;
        step(); check_all("rst2", 6'h00, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        // Saturation on the 4-bit counter copy
        mc_seq = 2'b01; op_offset = 6'h01;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) check("sat14.count_s", 32'(instr_count_s), 32'h0e);
            if (i == 15) check("sat15.count_s", 32'(instr_count_s), 32'h0f);
        end
        check("sat.count_s", 32'(instr_count_s), 32'h0f);
        check("sat.upc_s",   32'(upc_s),         32'h01);
        check("sat.halt_s",  32'(halted_s),      32'h0);
        check_all("count20", 6'h01, 1'b0, 1'b0, 16'h0014);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
